uart_tx_feeder: RTL

- Byte-buffering front end that sits directly upstream of the UART transmitter.
- Accepts bytes from the system side on a valid/ready interface and stores them in an internal FIFO.
- Dispatches them one at a time to the transmitter: a single-cycle tx_start pulse with tx_data held stable, then waits for tx_done before launching the next byte.
- Lets producers burst bytes at clock rate while the line drains at the baud rate.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_feeder.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line timing, byte width and the feeder FSM encoding.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT = 13021;
  localparam int unsigned DATA_W       = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    GAP
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; combinational count/full/empty/head derived from
// the pointers only.
// Ports: clk, rst (async active-low), push/push_data, pop/pop_data_c (head),
//        flush, count_c, full_c, empty_c.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = uart_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data_c,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count_c,
  output logic                       full_c,
  output logic                       empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign count_c    = wr_ptr - rd_ptr;
  assign full_c     = (count_c == CW'(DEPTH));
  assign empty_c    = (count_c == '0);
  assign pop_data_c = mem[rd_ptr[AW-1:0]];

  // Flush wins over both push and pop.
  assign do_push = push && !full_c && !flush;
  assign do_pop  = pop && !empty_c && !flush;

  // Pointer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer in front of a UART transmitter: queues producer bytes and launches
// them one at a time with a tx_start pulse, waiting for tx_done between bytes.
// Ports: clk, rst (async active-low); in_valid/in_data/in_ready producer side;
//        flush; tx_start/tx_data/tx_active/tx_done transmitter side;
//        count, empty, drop status.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DATA_W   = uart_pkg::DATA_W,
  parameter int unsigned GAP_CLKS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       drop
);

  localparam int unsigned GW      = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam bit          HAS_GAP = (GAP_CLKS > 0);

  feeder_state_t     state;
  feeder_state_t     state_nxt;
  logic              tx_start_nxt;
  logic [DATA_W-1:0] tx_data_nxt;
  logic [GW-1:0]     gap_cnt;
  logic [GW-1:0]     gap_cnt_nxt;
  logic              pop_c;
  logic [DATA_W-1:0] head_c;
  logic              full_c;

  // Completion is signalled by tx_done alone; busy level is not needed.
  logic unused_tx_active;
  assign unused_tx_active = tx_active;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_valid),
    .push_data  (in_data),
    .pop        (pop_c),
    .pop_data_c (head_c),
    .flush      (flush),
    .count_c    (count),
    .full_c     (full_c),
    .empty_c    (empty)
  );

  assign in_ready = !full_c;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    gap_cnt_nxt  = gap_cnt;
    pop_c        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !flush) begin
          pop_c        = 1'b1;
          tx_data_nxt  = head_c;
          tx_start_nxt = 1'b1;
          state_nxt    = START;
        end
      end
      START: state_nxt = BUSY;
      BUSY: begin
        if (tx_done) begin
          gap_cnt_nxt = '0;
          state_nxt   = HAS_GAP ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CLKS - 1)) state_nxt = IDLE;
        else                              gap_cnt_nxt = gap_cnt + GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      gap_cnt  <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      gap_cnt  <= gap_cnt_nxt;
      // A byte discarded by flush is not reported as a drop.
      drop     <= in_valid && !in_ready && !flush;
    end
  end

endmodule
